// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - ROM address/instruction and execute handshake bundle for the fetch unit
interface instruction_fetch_unit_if;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall;
  logic        iBranchValid;
  logic        iBranchTaken;
  logic        oValid;
  logic [3:0]  oOpcode;
  logic [7:0]  oDestination;
  logic [7:0]  oSourceA;
  logic [7:0]  oSourceB;
  logic [15:0] oImmediate;

  // Fetch unit side: drives address and decoded fields
  modport master (
    output oAddress, oValid, oOpcode, oDestination, oSourceA, oSourceB, oImmediate,
    input  iInstruction, iStall, iBranchValid, iBranchTaken
  );

  // ROM / execute side
  modport slave (
    input  oAddress, oValid, oOpcode, oDestination, oSourceA, oSourceB, oImmediate,
    output iInstruction, iStall, iBranchValid, iBranchTaken
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter, ROM fetch, field decode, local JMP and BLE hold
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_ADDRESS = 16'd0,
  parameter logic [3:0]  OPCODE_JMP    = 4'd5,
  parameter logic [3:0]  OPCODE_BLE    = 4'd2
) (
  input logic                     Clock,
  input logic                     Reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic {RUN, BRANCH_WAIT} state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic [15:0] saved_target, saved_target_next;
  logic        valid, valid_next;
  logic [3:0]  opcode, opcode_next;
  logic [7:0]  destination, destination_next;
  logic [7:0]  source_a, source_a_next;
  logic [7:0]  source_b, source_b_next;
  logic [15:0] immediate, immediate_next;
  logic [3:0]  fetched_opcode;
  logic [15:0] fetched_target;

  assign fetched_opcode = bus.iInstruction[27:24];
  assign fetched_target = {8'b0, bus.iInstruction[23:16]};

  // Next-state and next-output selection; everything holds unless a case below moves it
  always_comb begin
    state_next        = state;
    pc_next           = pc;
    saved_target_next = saved_target;
    valid_next        = valid;
    opcode_next       = opcode;
    destination_next  = destination;
    source_a_next     = source_a;
    source_b_next     = source_b;
    immediate_next    = immediate;
    case (state)
      RUN: begin
        if (!bus.iStall) begin
          if (fetched_opcode == OPCODE_JMP) begin
            // JMP is consumed here and never reaches execute: one bubble
            pc_next    = fetched_target;
            valid_next = 1'b0;
          end else begin
            valid_next       = 1'b1;
            opcode_next      = fetched_opcode;
            destination_next = bus.iInstruction[23:16];
            source_a_next    = bus.iInstruction[15:8];
            source_b_next    = bus.iInstruction[7:0];
            immediate_next   = bus.iInstruction[15:0];
            pc_next          = pc + 16'd1;
            if (fetched_opcode == OPCODE_BLE) begin
              // Fall-through is already in PC; keep the taken target until execute decides
              saved_target_next = fetched_target;
              state_next        = BRANCH_WAIT;
            end
          end
        end
      end
      BRANCH_WAIT: begin
        // Stall is irrelevant here: nothing is issued until the branch resolves
        valid_next = 1'b0;
        if (bus.iBranchValid) begin
          state_next = RUN;
          if (bus.iBranchTaken) begin
            pc_next = saved_target;
          end
        end
      end
      default: state_next = RUN;
    endcase
  end

  // State register with synchronous active-low reset taking priority over everything
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state        <= RUN;
      pc           <= RESET_ADDRESS;
      saved_target <= 16'd0;
      valid        <= 1'b0;
      opcode       <= 4'd0;
      destination  <= 8'd0;
      source_a     <= 8'd0;
      source_b     <= 8'd0;
      immediate    <= 16'd0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      saved_target <= saved_target_next;
      valid        <= valid_next;
      opcode       <= opcode_next;
      destination  <= destination_next;
      source_a     <= source_a_next;
      source_b     <= source_b_next;
      immediate    <= immediate_next;
    end
  end

  assign bus.oAddress     = pc;
  assign bus.oValid       = valid;
  assign bus.oOpcode      = opcode;
  assign bus.oDestination = destination;
  assign bus.oSourceA     = source_a;
  assign bus.oSourceB     = source_b;
  assign bus.oImmediate   = immediate;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LED = 4'd1;
  localparam logic [3:0] OP_BLE = 4'd2;
  localparam logic [3:0] OP_STO = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;

  typedef struct packed {
    logic [15:0] addr;
    logic        valid;
    logic [27:0] word;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        stall = 1'b0;
  logic        bvalid = 1'b0;
  logic        btaken = 1'b0;
  logic [27:0] rom [0:255];
  exp_t        qa[$];
  exp_t        qb[$];
  int          tests = 0;
  int          fails = 0;

  instruction_fetch_unit_if ifa ();
  instruction_fetch_unit_if ifb ();

  assign ifa.iInstruction = rom[ifa.oAddress[7:0]];
  assign ifa.iStall       = stall;
  assign ifa.iBranchValid = bvalid;
  assign ifa.iBranchTaken = btaken;
  assign ifb.iInstruction = rom[ifb.oAddress[7:0]];
  assign ifb.iStall       = stall;
  assign ifb.iBranchValid = bvalid;
  assign ifb.iBranchTaken = btaken;

  instruction_fetch_unit #(.RESET_ADDRESS(16'd0), .OPCODE_JMP(OP_JMP), .OPCODE_BLE(OP_BLE)) dut_a (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (ifa)
  );

  instruction_fetch_unit #(.RESET_ADDRESS(16'hFFFF), .OPCODE_JMP(OP_JMP), .OPCODE_BLE(OP_BLE)) dut_b (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (ifb)
  );

  always #5 Clock = ~Clock;

  function automatic exp_t mk(input logic [15:0] addr, input logic valid, input logic [27:0] word);
    exp_t e;
    e.addr  = addr;
    e.valid = valid;
    e.word  = word;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One clock edge of stimulus; expected outputs after that edge go to the scoreboard
  task automatic step(input logic rst_n, input logic st, input logic bv, input logic bt,
                      input exp_t ea, input logic use_b, input exp_t eb);
    Reset  = rst_n;
    stall  = st;
    bvalid = bv;
    btaken = bt;
    @(posedge Clock);
    qa.push_back(ea);
    if (use_b) qb.push_back(eb);
    #1;
  endtask

  task automatic run(input logic [15:0] addr, input logic valid, input logic [27:0] word);
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(addr, valid, word), 1'b0, mk(16'd0, 1'b0, 28'd0));
  endtask

  // Monitor: compare every observed cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a_address", {16'd0, ifa.oAddress}, {16'd0, e.addr});
        check("a_valid", {31'd0, ifa.oValid}, {31'd0, e.valid});
        check("a_fields", {ifa.oOpcode, ifa.oDestination, ifa.oSourceA, ifa.oSourceB},
              {4'd0, e.word});
        check("a_immediate", {16'd0, ifa.oImmediate}, {16'd0, e.word[15:0]});
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b_address", {16'd0, ifb.oAddress}, {16'd0, e.addr});
        check("b_valid", {31'd0, ifb.oValid}, {31'd0, e.valid});
        check("b_fields", {ifb.oOpcode, ifb.oDestination, ifb.oSourceA, ifb.oSourceB},
              {4'd0, e.word});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

  initial begin
    exp_t z;
    z = mk(16'd0, 1'b0, 28'd0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      rom[i] = {OP_NOP, b, ~b, b ^ 8'h5A};
    end
    rom[0]   = {OP_ADD, 8'h11, 8'h22, 8'h33};
    rom[1]   = {OP_STO, 8'h44, 8'h55, 8'h66};
    rom[2]   = {OP_SUB, 8'h77, 8'h88, 8'h99};
    rom[3]   = {OP_LED, 8'hAA, 8'hBB, 8'hCC};
    rom[9]   = {OP_BLE, 8'h08, 8'hDE, 8'hAD};
    rom[14]  = {OP_JMP, 8'h02, 8'h00, 8'h00};
    rom[255] = {OP_ADD, 8'h5A, 8'hC3, 8'h3C};

    // Reset held two cycles
    step(1'b0, 1'b0, 1'b0, 1'b0, z, 1'b0, z);
    step(1'b0, 1'b0, 1'b0, 1'b0, z, 1'b0, z);
    // Straight-line fetch of ADD/STO/SUB/LED
    run(16'd1, 1'b1, rom[0]);
    run(16'd2, 1'b1, rom[1]);
    run(16'd3, 1'b1, rom[2]);
    run(16'd4, 1'b1, rom[3]);
    // Stall three cycles: everything frozen
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(16'd4, 1'b1, rom[3]), 1'b0, z);
    for (int i = 4; i <= 8; i++) run(16'(i + 1), 1'b1, rom[i]);
    // BLE at 9, taken after three waiting cycles (stall ignored while waiting)
    run(16'd10, 1'b1, rom[9]);
    step(1'b1, 1'b1, 1'b0, 1'b0, mk(16'd10, 1'b0, rom[9]), 1'b0, z);
    run(16'd10, 1'b0, rom[9]);
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(16'd8, 1'b0, rom[9]), 1'b0, z);
    run(16'd9, 1'b1, rom[8]);
    // BLE at 9 again, not taken
    run(16'd10, 1'b1, rom[9]);
    run(16'd10, 1'b0, rom[9]);
    run(16'd10, 1'b0, rom[9]);
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(16'd10, 1'b0, rom[9]), 1'b0, z);
    for (int i = 10; i <= 13; i++) run(16'(i + 1), 1'b1, rom[i]);
    // JMP at 14 to 2: one bubble, fields keep the previous instruction
    run(16'd2, 1'b0, rom[13]);
    run(16'd3, 1'b1, rom[2]);
    // Branch pulse while running is ignored
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(16'd4, 1'b1, rom[3]), 1'b0, z);
    for (int i = 4; i <= 8; i++) run(16'(i + 1), 1'b1, rom[i]);
    run(16'd10, 1'b1, rom[9]);
    // Reset during BRANCH_WAIT, then a stale branch pulse
    step(1'b0, 1'b0, 1'b0, 1'b0, z, 1'b0, z);
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(16'd1, 1'b1, rom[0]), 1'b0, z);
    // PC wrap on the instance reset to 16'hFFFF
    step(1'b0, 1'b0, 1'b0, 1'b0, z, 1'b1, mk(16'hFFFF, 1'b0, 28'd0));
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(16'd1, 1'b1, rom[0]), 1'b1, mk(16'h0000, 1'b1, rom[255]));
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(16'd2, 1'b1, rom[1]), 1'b1, mk(16'h0001, 1'b1, rom[0]));

    repeat (2) @(posedge Clock);
    check("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
